// File: rtl/updown_mod_counter.sv
// updown_mod_counter: parametrised loadable up/down modulo counter
// with wrap, saturate and one-shot modes plus registered status flags.
module updown_mod_counter #(
  parameter int WIDTH   = 4,
  parameter int MAX_VAL = 2**WIDTH-1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en_i,
  input  logic             up_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic [1:0]       mode_i,
  input  logic             clr_flags_i,
  output logic [WIDTH-1:0] count_o,
  output logic             wrap_o,
  output logic             ovf_o,
  output logic             busy_o,
  output logic             done_o
);
  localparam logic [0:0]       S_IDLE = 1'b0;
  localparam logic [0:0]       S_RUN  = 1'b1;
  localparam logic [WIDTH-1:0] L_MAX  = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] L_ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] L_ZERO = '0;
  logic [WIDTH-1:0] r_count, w_count, w_term, w_step, w_load_val;
  logic [0:0]       r_state, w_state;
  logic             r_wrap, w_wrap, r_ovf, w_ovf_set, r_done, w_done;
  logic             w_at_term, w_sat, w_oneshot;
  assign w_term     = up_i ? L_MAX : L_ZERO;
  assign w_at_term  = r_count == w_term;
  assign w_step     = up_i ? r_count + L_ONE : r_count - L_ONE;
  assign w_load_val = load_val_i > L_MAX ? L_MAX : load_val_i;
  assign w_sat      = mode_i == 2'b01;
  assign w_oneshot  = mode_i == 2'b10;
  // Leaving one-shot mode drops the FSM to IDLE without a done pulse.
  always_comb begin
    w_count   = r_count;
    w_state   = S_IDLE;
    w_wrap    = 1'b0;
    w_done    = 1'b0;
    w_ovf_set = 1'b0;
    if (load_i) begin
      w_count = w_load_val;
      w_state = w_oneshot ? S_RUN : S_IDLE;
    end else if (w_oneshot) begin
      w_state = r_state;
      if (r_state == S_RUN && en_i) begin
        w_count = w_at_term ? r_count : w_step;
        w_done  = w_at_term || w_step == w_term;
        w_state = w_done ? S_IDLE : S_RUN;
      end
    end else if (en_i) begin
      w_count   = !w_at_term ? w_step : w_sat ? r_count : (up_i ? L_ZERO : L_MAX);
      w_wrap    = w_at_term && !w_sat;
      w_ovf_set = w_at_term;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= L_ZERO;
      r_state <= S_IDLE;
      r_wrap  <= 1'b0;
      r_done  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_count <= w_count;
      r_state <= w_state;
      r_wrap  <= w_wrap;
      r_done  <= w_done;
      r_ovf   <= w_ovf_set | (r_ovf & ~clr_flags_i);
    end
  end
  assign count_o = r_count;
  assign wrap_o  = r_wrap;
  assign ovf_o   = r_ovf;
  assign busy_o  = r_state == S_RUN;
  assign done_o  = r_done;
endmodule

// File: tb/tb_updown_mod_counter.sv
// tb_updown_mod_counter: directed stimulus, per-cycle comparison against an
// arithmetic reference model, plus hand-computed literal checkpoints.
module tb_updown_mod_counter;
  localparam int W  = 4;
  localparam int MX = 9;
  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         en_i = 1'b0, up_i = 1'b0, load_i = 1'b0, clr_flags_i = 1'b0;
  logic [W-1:0] load_val_i = '0;
  logic [1:0]   mode_i = 2'b00;
  logic [W-1:0] count_o;
  logic         wrap_o, ovf_o, busy_o, done_o;
  int n_chk = 0, n_fail = 0;
  int m_cnt = 0, m_wrap = 0, m_ovf = 0, m_run = 0, m_done = 0;

  updown_mod_counter #(.WIDTH(W), .MAX_VAL(MX)) dut (
    .clk(clk), .reset(reset), .en_i(en_i), .up_i(up_i), .load_i(load_i),
    .load_val_i(load_val_i), .mode_i(mode_i), .clr_flags_i(clr_flags_i),
    .count_o(count_o), .wrap_o(wrap_o), .ovf_o(ovf_o), .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Reference model: plain integer arithmetic on the counting rules.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_cnt = 0; m_wrap = 0; m_ovf = 0; m_run = 0; m_done = 0;
    end else begin
      int term, lv, set;
      term = up_i ? MX : 0;
      lv = (int'(load_val_i) > MX) ? MX : int'(load_val_i);
      set = 0; m_wrap = 0; m_done = 0;
      if (load_i) begin
        m_cnt = lv;
        m_run = (mode_i == 2) ? 1 : 0;
      end else if (mode_i == 2) begin
        if (m_run == 1 && en_i) begin
          if (m_cnt == term) begin
            m_done = 1; m_run = 0;
          end else begin
            m_cnt = up_i ? m_cnt + 1 : m_cnt - 1;
            if (m_cnt == term) begin
              m_done = 1; m_run = 0;
            end
          end
        end
      end else begin
        m_run = 0;
        if (en_i) begin
          if (m_cnt == term) begin
            set = 1;
            if (mode_i != 1) begin
              m_cnt = up_i ? 0 : MX;
              m_wrap = 1;
            end
          end else m_cnt = up_i ? m_cnt + 1 : m_cnt - 1;
        end
      end
      m_ovf = set ? 1 : (clr_flags_i ? 0 : m_ovf);
    end
  end

  always @(negedge clk) begin
    chk("cyc_count", int'(count_o), m_cnt);
    chk("cyc_wrap", int'(wrap_o), m_wrap);
    chk("cyc_ovf", int'(ovf_o), m_ovf);
    chk("cyc_busy", int'(busy_o), m_run);
    chk("cyc_done", int'(done_o), m_done);
  end

  task automatic cyc(input bit e, input bit u, input bit l, input int v, input int m, input bit c);
    en_i = e; up_i = u; load_i = l; load_val_i = W'(v); mode_i = 2'(m); clr_flags_i = c;
    @(posedge clk);
    #1;
  endtask

  task automatic pin(input string name, input int cnt, input int wr, input int ov, input int bs, input int dn);
    chk({name, "_count"}, int'(count_o), cnt);
    chk({name, "_wrap"}, int'(wrap_o), wr);
    chk({name, "_ovf"}, int'(ovf_o), ov);
    chk({name, "_busy"}, int'(busy_o), bs);
    chk({name, "_done"}, int'(done_o), dn);
  endtask

  initial begin
    #17;
    pin("reset", 0, 0, 0, 0, 0);
    reset = 1'b0;
    // wrap mode, up from reset
    for (int i = 1; i <= 9; i++) cyc(1, 1, 0, 0, 0, 0);
    pin("up_to_max", 9, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0);
    pin("up_wrap", 0, 1, 1, 0, 0);
    cyc(1, 1, 0, 0, 0, 0);
    pin("after_wrap", 1, 0, 1, 0, 0);
    cyc(0, 1, 0, 0, 0, 1);
    pin("clr", 1, 0, 0, 0, 0);
    // direction flip at 5
    cyc(1, 1, 1, 5, 0, 0);
    pin("load5", 5, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0);
    pin("up6", 6, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    pin("down4", 4, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0, 0, 0);
    pin("down0", 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    pin("down_wrap", 9, 1, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 1);
    // saturate mode, down
    cyc(1, 0, 1, 2, 1, 0);
    pin("sat_load", 2, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 1, 0);
    cyc(1, 0, 0, 0, 1, 0);
    pin("sat_0", 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 1, 0);
    pin("sat_hold", 0, 0, 1, 0, 0);
    cyc(1, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 1, 1);
    pin("sat_clr", 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 1, 1);
    pin("set_over_clr", 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 1, 1);
    // clamped load with en
    cyc(1, 1, 1, 15, 0, 0);
    pin("clamp", 9, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0);
    pin("clamp_wrap", 0, 1, 1, 0, 0);
    cyc(0, 1, 0, 0, 0, 1);
    // one-shot, en toggling
    cyc(1, 1, 0, 0, 2, 0);
    pin("os_idle_hold", 0, 0, 0, 0, 0);
    cyc(0, 1, 1, 6, 2, 0);
    pin("os_load", 6, 0, 0, 1, 0);
    cyc(1, 1, 0, 0, 2, 0);
    cyc(0, 1, 0, 0, 2, 0);
    pin("os_7", 7, 0, 0, 1, 0);
    cyc(1, 1, 0, 0, 2, 0);
    cyc(0, 1, 0, 0, 2, 0);
    cyc(1, 1, 0, 0, 2, 0);
    pin("os_done", 9, 0, 0, 0, 1);
    cyc(1, 1, 0, 0, 2, 0);
    pin("os_after", 9, 0, 0, 0, 0);
    // one-shot loaded at terminal
    cyc(1, 1, 1, 9, 2, 0);
    pin("os_term_load", 9, 0, 0, 1, 0);
    cyc(1, 1, 0, 0, 2, 0);
    pin("os_term_step", 9, 0, 0, 0, 1);
    // mode change mid-run
    cyc(1, 1, 1, 2, 2, 0);
    cyc(1, 1, 0, 0, 2, 0);
    pin("os_run3", 3, 0, 0, 1, 0);
    cyc(1, 1, 0, 0, 0, 0);
    pin("os_abort", 4, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0);
    pin("os_abort_cnt", 5, 0, 0, 0, 0);
    // async reset mid-run
    cyc(1, 1, 1, 2, 2, 0);
    cyc(1, 1, 0, 0, 2, 0);
    pin("os_rerun", 3, 0, 0, 1, 0);
    reset = 1'b1;
    #1;
    pin("async_reset", 0, 0, 0, 0, 0);
    #10;
    reset = 1'b0;
    cyc(1, 1, 0, 0, 2, 0);
    pin("post_reset", 0, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0);
    pin("post_reset_up", 1, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/updown_mod_counter.md
# updown_mod_counter

Parametrised loadable up/down modulo counter, the next generation of the team's 4-bit loadable counter. It adds width and modulus parameters, direction control, count enable, wrap, saturate and one-shot modes, and status flags. It serves as the general-purpose counter for timers, pointers and event counting in the design. All outputs are registered.

## Interface
- WIDTH, 4, counter width in bits (≥ 2)
- MAX_VAL, 2**WIDTH-1, terminal count in the up direction; legal range 1..2**WIDTH-1
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-high; clock clk
- en_i  input  1  count enable; one step per cycle while high
- up_i  input  1  direction: 1 = increment, 0 = decrement
- load_i  input  1  load load_val_i this cycle
- load_val_i  input  WIDTH  load value
- mode_i  input  2  00 wrap, 01 saturate, 10 one-shot, 11 reserved (behaves as wrap)
- clr_flags_i  input  1  clears sticky ovf_o
- count_o  output  WIDTH  current count
- wrap_o  output  1  one-cycle pulse, coincident with count_o showing the wrapped value
- ovf_o  output  1  sticky: a step beyond a terminal was attempted
- busy_o  output  1  one-shot run in progress
- done_o  output  1  one-cycle pulse when a one-shot run reaches its terminal

## Operation
- Terminal value: MAX_VAL when up_i=1; 0 when up_i=0.
- Priority per cycle: reset > load_i > en_i step > hold.
- Load: count_o <= min(load_val_i, MAX_VAL). No step happens in a load cycle, even if en_i=1. A load never sets wrap_o or ovf_o.
- Step with count below terminal (up) or above terminal (down): count_o ± 1.
- Step at terminal, wrap mode: up goes MAX_VAL -> 0, down goes 0 -> MAX_VAL. wrap_o=1 next cycle. ovf_o set.
- Step at terminal, saturate mode: count holds. wrap_o stays 0. ovf_o set.
- One-shot FSM has states IDLE and RUN.
  - IDLE: count holds regardless of en_i. load_i in mode 10 loads and goes to RUN.
  - RUN: steps on en_i. A step that makes count equal the terminal goes to IDLE and pulses done_o with the terminal value.
  - A load while in RUN reloads and stays in RUN.
  - A load whose clamped value already equals the terminal enters RUN anyway. The first enabled step then ends the run: count holds, done_o pulses, ovf_o is not set.
  - busy_o = (state == RUN).
- Any cycle with mode_i ≠ 10 forces the FSM to IDLE without a done_o pulse. The counter then follows the current mode.
- up_i may change in any cycle; the terminal is re-evaluated every cycle.
- ovf_o: set has priority over clr_flags_i in the same cycle. Otherwise clr_flags_i clears it to 0.
- Arithmetic is modulo 2**WIDTH internally. count_o never exceeds MAX_VAL.

## Timing
- Reset (async assert; deassertion synchronised externally) gives count_o=0, wrap_o=0, ovf_o=0, busy_o=0, done_o=0, FSM IDLE.
- Reset mid-run aborts immediately. No done_o pulse.
- Latency is 1 cycle from input sample to count_o and flag update.
- wrap_o and done_o are high for exactly one cycle per event. Back-to-back events give consecutive pulses.
- ovf_o rises the cycle after the offending step and falls the cycle after clr_flags_i.
- No combinational path from inputs to outputs.

## Test plan
- WIDTH=4, MAX_VAL=9, mode 00, up, en=1 from reset: count 0..9, 0. wrap_o high exactly when count_o=0 after 9. ovf_o=1 thereafter.
- Mode 01, down, load 2, en=1: count 2,1,0,0,0. wrap_o never asserted. ovf_o=1 one cycle after the first held step. clr_flags_i with en=0 clears it.
- Load 15 with MAX_VAL=9 and en_i=1 in the same cycle: count_o=9, no step, no flags. Next up step in wrap mode gives 0 with wrap_o=1.
- Mode 10, load 6, up, en toggled 1/0: busy_o=1, count reaches 9 after 3 enabled steps. done_o pulses once, busy_o=0, count holds at 9 while en=1.
- Mode 10 run: mode_i switched to 00 mid-run gives busy_o=0 next cycle, no done_o, counting continues in wrap mode. A repeat run with reset asserted mid-run gives all outputs 0 asynchronously.
- Direction flip at count 5 (up to down) with en=1 gives 6, then 5, 4. In wrap mode, down through 0 gives 9 with a wrap_o pulse.
